kernel_pr_dataflow_start_ctrl: RTL

Top-level start/done sequencer for the kernel_pr dataflow region. Accepts the kernel's ap_ctrl_chain handshake and broadcasts one start token per iteration into every stage's start FIFO (shift-register start FIFOs, depth 4). It collects per-stage done pulses, retires an iteration once every stage has finished it, and bounds the number of iterations in flight to the start-FIFO depth.

---
 rtl/kernel_pr_ctrl_pkg.sv | 7 +
 rtl/kernel_pr_dataflow_start_ctrl_if.sv | 26 ++
 rtl/kernel_pr_done_counter.sv | 27 ++
 rtl/kernel_pr_dataflow_start_ctrl.sv | 72 +++++++
 4 files changed

// File: rtl/kernel_pr_ctrl_pkg.sv
// Shared constants and types for the kernel_pr dataflow start/done control.
package kernel_pr_ctrl_pkg;
  localparam int START_FIFO_DEPTH = 4;
  localparam int CNT_WIDTH        = 3;

  typedef logic [CNT_WIDTH-1:0] cnt_t;
endpackage

// File: rtl/kernel_pr_dataflow_start_ctrl_if.sv
// ap_ctrl_chain handshake plus per-stage start/done buses of the dataflow region.
interface kernel_pr_dataflow_start_ctrl_if #(
  parameter int NUM_STAGES = 4,
  parameter int CNT_WIDTH  = 3
);
  logic                  ap_start;
  logic                  ap_ready;
  logic                  ap_done;
  logic                  ap_continue;
  logic                  ap_idle;
  logic [NUM_STAGES-1:0] start_write;
  logic [NUM_STAGES-1:0] start_full_n;
  logic [NUM_STAGES-1:0] stage_done;
  logic [CNT_WIDTH-1:0]  inflight;
  logic                  err_overflow;

  modport master (
    output ap_start, ap_continue, start_full_n, stage_done,
    input  ap_ready, ap_done, ap_idle, start_write, inflight, err_overflow
  );

  modport slave (
    input  ap_start, ap_continue, start_full_n, stage_done,
    output ap_ready, ap_done, ap_idle, start_write, inflight, err_overflow
  );
endinterface

// File: rtl/kernel_pr_done_counter.sv
// Per-stage count of finished-but-unretired iterations; never wraps, and
// an increment past the in-flight limit is dropped and reported.
module kernel_pr_done_counter
  import kernel_pr_ctrl_pkg::*;
#(
  parameter int W = CNT_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  input  logic [W-1:0] limit,
  output logic         nonzero,
  output logic         overflow
);
  logic [W-1:0] cnt;

  // A stage cannot have finished more iterations than are in flight.
  assign overflow = inc & ~dec & ((cnt == limit) | (&cnt));
  assign nonzero  = (cnt != '0);

  always_ff @(posedge clk) begin
    if (reset)                           cnt <= '0;
    else if (inc & ~dec & ~overflow)     cnt <= cnt + 1'b1;
    else if (dec & ~inc & nonzero)       cnt <= cnt - 1'b1;
  end
endmodule

// File: rtl/kernel_pr_dataflow_start_ctrl.sv
// Start/done sequencer: broadcasts start tokens to all stage FIFOs, retires
// iterations once every stage is done, and caps iterations in flight.
module kernel_pr_dataflow_start_ctrl
  import kernel_pr_ctrl_pkg::*;
#(
  parameter int NUM_STAGES   = 4,
  parameter int MAX_INFLIGHT = START_FIFO_DEPTH,
  parameter int CNT_WIDTH    = kernel_pr_ctrl_pkg::CNT_WIDTH
) (
  input logic                       clk,
  input logic                       reset,
  kernel_pr_dataflow_start_ctrl_if.slave bus
);
  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_INFLIGHT);

  logic [CNT_WIDTH-1:0]  inflight;
  logic [CNT_WIDTH-1:0]  done_pend;
  logic [CNT_WIDTH-1:0]  pend_next;
  logic                  ap_done_q;
  logic                  err_q;
  logic [NUM_STAGES-1:0] nonzero;
  logic [NUM_STAGES-1:0] ovf;
  logic                  issue;
  logic                  retire;
  logic                  ack;

  // Atomic broadcast: one blocked FIFO holds back every stage.
  assign issue  = bus.ap_start & (&bus.start_full_n) & (inflight < MAX_CNT);
  assign retire = &nonzero;
  assign ack    = ap_done_q & bus.ap_continue;

  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_cnt
    kernel_pr_done_counter #(.W(CNT_WIDTH)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .inc      (bus.stage_done[i]),
      .dec      (retire),
      .limit    (inflight),
      .nonzero  (nonzero[i]),
      .overflow (ovf[i])
    );
  end

  always_comb begin
    pend_next = done_pend;
    if (retire & ~ack)      pend_next = done_pend + 1'b1;
    else if (ack & ~retire) pend_next = done_pend - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight  <= '0;
      done_pend <= '0;
      ap_done_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (issue & ~ack)      inflight <= inflight + 1'b1;
      else if (ack & ~issue) inflight <= inflight - 1'b1;
      done_pend <= pend_next;
      // Track the next pending count so ap_done rises in the cycle after retire.
      ap_done_q <= (pend_next != '0);
      err_q     <= err_q | (|ovf);
    end
  end

  assign bus.start_write  = {NUM_STAGES{issue}};
  assign bus.ap_ready     = issue;
  assign bus.ap_done      = ap_done_q;
  assign bus.ap_idle      = (inflight == '0) & (done_pend == '0) & ~(|nonzero);
  assign bus.inflight     = inflight;
  assign bus.err_overflow = err_q;
endmodule
